// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to 8-bit binary converter with a start/busy/done handshake.
// One digit is folded per cycle, most significant first, as acc = acc*10 + digit.
module bcd_to_bin #(
   parameter int DIGITS   = 3,
   parameter bit SATURATE = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [4*DIGITS-1:0] bcd_in,
   output logic                busy,
   output logic                done,
   output logic [7:0]          bin_out,
   output logic                ovf,
   output logic                invalid
);
   localparam int AW = 4*DIGITS;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, DONE = 2'd2} state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] opnd;
   logic [AW-1:0] acc;
   logic [AW-1:0] acc_nxt;
   logic [IW-1:0] idx;
   logic [3:0]    digit;
   logic [31:0]   acc_ext;

   function automatic logic [7:0] sat_result(input logic [31:0] v);
      if ((v > 32'd255) && SATURATE)
         return 8'hFF;
      return v[7:0];
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CONV;
         CONV:    if (idx == '0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Raw nibble is accumulated even when it is not a decimal digit.
   always_comb begin
      digit = 4'd0;
      for (int i = 0; i < DIGITS; i++)
         if (idx == IW'(i)) digit = opnd[4*i +: 4];
      acc_nxt = acc * AW'(10) + AW'(digit);
      acc_ext = 32'(acc_nxt);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opnd    <= '0;
         acc     <= '0;
         idx     <= '0;
         bin_out <= 8'h00;
         ovf     <= 1'b0;
         invalid <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               opnd    <= bcd_in;
               acc     <= '0;
               idx     <= IW'(DIGITS-1);
               bin_out <= 8'h00;
               ovf     <= 1'b0;
               invalid <= 1'b0;
            end
            CONV: begin
               acc <= acc_nxt;
               idx <= idx - IW'(1);
               if (digit > 4'd9) invalid <= 1'b1;
               // Results are latched on the final digit and held until the next start.
               if (idx == '0) begin
                  ovf     <= (acc_ext > 32'd255);
                  bin_out <= sat_result(acc_ext);
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin: three-digit saturating and wrapping instances
// plus a single-digit instance, checked against hand-computed results.
module tb_bcd_to_bin;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start3 = 1'b0;
   logic        start1 = 1'b0;
   logic [11:0] bcd3 = 12'h000;
   logic [3:0]  bcd1 = 4'h0;

   logic       busy_a, done_a, ovf_a, inv_a;
   logic [7:0] bin_a;
   logic       busy_b, done_b, ovf_b, inv_b;
   logic [7:0] bin_b;
   logic       busy_c, done_c, ovf_c, inv_c;
   logic [7:0] bin_c;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   bcd_to_bin #(.DIGITS(3), .SATURATE(1'b1)) dut_a (
      .clk(clk), .rst(rst), .start(start3), .bcd_in(bcd3),
      .busy(busy_a), .done(done_a), .bin_out(bin_a), .ovf(ovf_a), .invalid(inv_a));

   bcd_to_bin #(.DIGITS(3), .SATURATE(1'b0)) dut_b (
      .clk(clk), .rst(rst), .start(start3), .bcd_in(bcd3),
      .busy(busy_b), .done(done_b), .bin_out(bin_b), .ovf(ovf_b), .invalid(inv_b));

   bcd_to_bin #(.DIGITS(1), .SATURATE(1'b1)) dut_c (
      .clk(clk), .rst(rst), .start(start1), .bcd_in(bcd1),
      .busy(busy_c), .done(done_c), .bin_out(bin_c), .ovf(ovf_c), .invalid(inv_c));

   // Runs one three-digit conversion and records what both instances show while done is high.
   task automatic run3(input logic [11:0] v, output int lat, output int bcnt, output int dcnt,
                       output logic [7:0] ba, output logic oa, output logic ia,
                       output logic [7:0] bb, output logic ob, output logic ib);
      lat = -1; bcnt = 0; dcnt = 0;
      ba = 8'hxx; oa = 1'bx; ia = 1'bx; bb = 8'hxx; ob = 1'bx; ib = 1'bx;
      @(negedge clk); bcd3 = v; start3 = 1'b1;
      @(negedge clk); start3 = 1'b0; bcd3 = 12'hFFF;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) @(negedge clk);
         if (busy_a) bcnt++;
         if (done_a) begin
            dcnt++;
            if (lat < 0) lat = k;
            ba = bin_a; oa = ovf_a; ia = inv_a;
            bb = bin_b; ob = ovf_b; ib = inv_b;
         end
      end
   endtask

   task automatic run1(input logic [3:0] v, output int lat, output int dcnt,
                       output logic [7:0] b, output logic o, output logic i);
      lat = -1; dcnt = 0; b = 8'hxx; o = 1'bx; i = 1'bx;
      @(negedge clk); bcd1 = v; start1 = 1'b1;
      @(negedge clk); start1 = 1'b0; bcd1 = 4'h0;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) @(negedge clk);
         if (done_c) begin
            dcnt++;
            if (lat < 0) lat = k;
            b = bin_c; o = ovf_c; i = inv_c;
         end
      end
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #1;
      n_chk++; if ({busy_a, done_a, ovf_a, inv_a} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags3: got %b expected 0000", {busy_a, done_a, ovf_a, inv_a}); end
      n_chk++; if (bin_a !== 8'h00) begin n_fail++; $display("FAIL reset_bin3: got %h expected 00", bin_a); end
      n_chk++; if ({busy_c, done_c, ovf_c, inv_c, bin_c} !== 12'h000) begin n_fail++; $display("FAIL reset_dig1: got %h expected 000", {busy_c, done_c, ovf_c, inv_c, bin_c}); end
      @(negedge clk); @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_basic();
      int lat, bcnt, dcnt; logic [7:0] ba, bb; logic oa, ia, ob, ib;
      run3(12'h255, lat, bcnt, dcnt, ba, oa, ia, bb, ob, ib);
      n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL basic_latency: got %0d expected 3", lat); end
      n_chk++; if (bcnt !== 4) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 4", bcnt); end
      n_chk++; if (dcnt !== 1) begin n_fail++; $display("FAIL basic_done_cycles: got %0d expected 1", dcnt); end
      n_chk++; if (ba !== 8'hFF) begin n_fail++; $display("FAIL basic_bin: got %h expected ff", ba); end
      n_chk++; if ({oa, ia} !== 2'b00) begin n_fail++; $display("FAIL basic_flags: got %b expected 00", {oa, ia}); end
      n_chk++; if ({bin_a, done_a, busy_a} !== 10'b1111_1111_00) begin n_fail++; $display("FAIL basic_hold: got %b expected 1111111100", {bin_a, done_a, busy_a}); end
   endtask

   task automatic test_overflow();
      int lat, bcnt, dcnt; logic [7:0] ba, bb; logic oa, ia, ob, ib;
      run3(12'h256, lat, bcnt, dcnt, ba, oa, ia, bb, ob, ib);
      n_chk++; if ({ba, oa} !== {8'hFF, 1'b1}) begin n_fail++; $display("FAIL ovf256_sat: got %h/%b expected ff/1", ba, oa); end
      n_chk++; if ({bb, ob} !== {8'h00, 1'b1}) begin n_fail++; $display("FAIL ovf256_wrap: got %h/%b expected 00/1", bb, ob); end
      run3(12'h999, lat, bcnt, dcnt, ba, oa, ia, bb, ob, ib);
      n_chk++; if ({ba, oa, ia} !== {8'hFF, 2'b10}) begin n_fail++; $display("FAIL ovf999_sat: got %h/%b/%b expected ff/1/0", ba, oa, ia); end
      n_chk++; if ({bb, ob} !== {8'hE7, 1'b1}) begin n_fail++; $display("FAIL ovf999_wrap: got %h/%b expected e7/1", bb, ob); end
      n_chk++; if (dut_a.acc !== 12'd999) begin n_fail++; $display("FAIL ovf999_acc: got %0d expected 999", dut_a.acc); end
   endtask

   task automatic test_invalid();
      int lat, bcnt, dcnt; logic [7:0] ba, bb; logic oa, ia, ob, ib;
      run3(12'h1A3, lat, bcnt, dcnt, ba, oa, ia, bb, ob, ib);
      n_chk++; if ({ba, oa, ia} !== {8'hCB, 2'b01}) begin n_fail++; $display("FAIL invalid_1a3: got %h/%b/%b expected cb/0/1", ba, oa, ia); end
      n_chk++; if ({bb, ib} !== {8'hCB, 1'b1}) begin n_fail++; $display("FAIL invalid_1a3_wrap: got %h/%b expected cb/1", bb, ib); end
      run3(12'h000, lat, bcnt, dcnt, ba, oa, ia, bb, ob, ib);
      n_chk++; if ({ba, oa, ia} !== {8'h00, 2'b00}) begin n_fail++; $display("FAIL zero_result: got %h/%b/%b expected 00/0/0", ba, oa, ia); end
      n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL zero_latency: got %0d expected 3", lat); end
   endtask

   task automatic test_back_to_back();
      logic [11:0] tbl [20];
      logic [7:0]  expv [4];
      logic        exp_busy, exp_done;
      tbl = '{12'h012, 12'h345, 12'h678, 12'h901, 12'h234, 12'h099, 12'h111, 12'h222, 12'h333, 12'h444,
              12'h200, 12'h555, 12'h666, 12'h777, 12'h888, 12'h137, 12'h321, 12'h654, 12'h987, 12'h246};
      expv = '{8'h0C, 8'h63, 8'hC8, 8'h89};
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         exp_busy = (c >= 1) && (((c - 1) % 5) != 4);
         exp_done = ((c % 5) == 4);
         n_chk++; if ({busy_a, busy_b} !== {2{exp_busy}}) begin n_fail++; $display("FAIL b2b_busy c=%0d: got %b expected %b", c, {busy_a, busy_b}, {2{exp_busy}}); end
         n_chk++; if ({done_a, done_b} !== {2{exp_done}}) begin n_fail++; $display("FAIL b2b_done c=%0d: got %b expected %b", c, {done_a, done_b}, {2{exp_done}}); end
         if (exp_done) begin
            n_chk++; if ({bin_a, bin_b} !== {2{expv[c/5]}}) begin n_fail++; $display("FAIL b2b_bin c=%0d: got %h/%h expected %h", c, bin_a, bin_b, expv[c/5]); end
         end
         bcd3 = tbl[c]; start3 = 1'b1;
      end
      @(negedge clk); start3 = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int lat, bcnt, dcnt, seen; logic [7:0] ba, bb; logic oa, ia, ob, ib;
      @(negedge clk); bcd3 = 12'h123; start3 = 1'b1;
      @(negedge clk); start3 = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      n_chk++; if ({busy_a, done_a, ovf_a, inv_a, bin_a} !== 12'h000) begin n_fail++; $display("FAIL midrst_outputs: got %h expected 000", {busy_a, done_a, ovf_a, inv_a, bin_a}); end
      n_chk++; if (dut_a.acc !== 12'h000) begin n_fail++; $display("FAIL midrst_acc: got %h expected 000", dut_a.acc); end
      @(negedge clk); @(negedge clk); rst = 1'b0;
      seen = 0;
      repeat (8) begin @(negedge clk); if (done_a || busy_a) seen++; end
      n_chk++; if (seen !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d active cycles expected 0", seen); end
      run3(12'h042, lat, bcnt, dcnt, ba, oa, ia, bb, ob, ib);
      n_chk++; if ({ba, oa, ia} !== {8'h2A, 2'b00}) begin n_fail++; $display("FAIL midrst_restart: got %h/%b/%b expected 2a/0/0", ba, oa, ia); end
      n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL midrst_latency: got %0d expected 3", lat); end
   endtask

   task automatic test_digits1();
      int lat, dcnt; logic [7:0] b; logic o, i;
      run1(4'h7, lat, dcnt, b, o, i);
      n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL dig1_latency: got %0d expected 1", lat); end
      n_chk++; if (dcnt !== 1) begin n_fail++; $display("FAIL dig1_done_cycles: got %0d expected 1", dcnt); end
      n_chk++; if ({b, o, i} !== {8'h07, 2'b00}) begin n_fail++; $display("FAIL dig1_seven: got %h/%b/%b expected 07/0/0", b, o, i); end
      run1(4'hF, lat, dcnt, b, o, i);
      n_chk++; if ({b, o, i} !== {8'h0F, 2'b01}) begin n_fail++; $display("FAIL dig1_invalid: got %h/%b/%b expected 0f/0/1", b, o, i); end
      n_chk++; if (busy_c !== 1'b0) begin n_fail++; $display("FAIL dig1_idle: got %b expected 0", busy_c); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_invalid();
      test_back_to_back();
      test_reset_mid();
      test_digits1();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_to_bin.md
# bcd_to_bin

Sequential packed-BCD to binary converter for the CTI-8 datapath. The decimal adjust logic produces BCD results; this block turns BCD operands (for example, decimal keypad or display values) back into 8-bit binary for the ALU. Each conversion folds one digit per cycle, most significant digit first, using `acc = acc*10 + digit`. It has a start/busy/done handshake and reports overflow and invalid-digit status.

## Interface
Parameters:
- `DIGITS`, 3: number of BCD digits in `bcd_in`. Valid range is 1 to 4.
- `SATURATE`, 1: on overflow, 1 forces `bin_out` to 8'hFF; 0 outputs the low 8 bits of the accumulator.

Ports (one clock; reset is asynchronous and active-high):
- `clk`, in, 1: clock. All state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: request a conversion. Sampled only in IDLE.
- `bcd_in`, in, 4*DIGITS: packed BCD operand. Digit DIGITS-1 is in the MSBs. Captured on the accepting edge.
- `busy`, out, 1: high in CONV and DONE.
- `done`, out, 1: one-cycle pulse; the result outputs are valid while it is high.
- `bin_out`, out, 8: binary result.
- `ovf`, out, 1: the decimal value exceeds 255.
- `invalid`, out, 1: at least one nibble was greater than 9.

## Operation
- Internal state:
  - Operand register, 4*DIGITS bits.
  - Accumulator `acc`, 4*DIGITS bits. This width is always sufficient because 10^DIGITS < 16^DIGITS.
  - Digit index.
  - Sticky invalid bit.
- States: IDLE, CONV, DONE.
- IDLE, when `start`=1 at an edge:
  - Capture `bcd_in`.
  - Clear `acc`, `bin_out`, `ovf` and `invalid`.
  - Set the digit index to DIGITS-1 and go to CONV.
- IDLE, when `start`=0: hold state and all outputs.
- CONV, each edge:
  - Compute `acc <= acc*10 + d`, where d is the indexed nibble. Arithmetic is unsigned at accumulator width.
  - If d > 9, set `invalid`. The raw nibble value (10–15) is still accumulated; no correction is applied.
  - Decrement the index. After digit 0 is processed, go to DONE.
- Entering DONE:
  - `ovf` = (final acc > 255).
  - `bin_out` = 8'hFF if `ovf` and SATURATE=1; otherwise `acc[7:0]`.
- DONE: `done`=1 for exactly one cycle, then return unconditionally to IDLE.
- Result retention: `bin_out`, `ovf` and `invalid` hold after DONE until the next accepted `start`.
- `start` is ignored in CONV and DONE. Changes on `bcd_in` after capture have no effect.
- Reset values: state = IDLE; `busy`=0, `done`=0, `bin_out`=8'h00, `ovf`=0, `invalid`=0; accumulator, operand register and index are all zero.
- Reset asserted mid-conversion: the conversion is aborted immediately and asynchronously. No `done` pulse is produced for it. The first `start` after reset deasserts begins a fresh conversion.

## Timing
- Let edge E be the edge that samples `start`=1 in IDLE.
  - `busy` rises after edge E.
  - The DIGITS CONV edges are E+1 through E+DIGITS.
  - `done`=1 in the cycle after edge E+DIGITS.
  - `busy` falls after edge E+DIGITS+1.
- Conversion latency is DIGITS+1 edges from the accepting edge to the end of the `done` cycle.
- If `start` is held continuously high, a new conversion is accepted every DIGITS+2 edges: the IDLE cycle following DONE samples it.
- `done`, `busy` and all result outputs are registered; none depend combinationally on inputs.

## Test plan
- DIGITS=3: `bcd_in`=12'h255, one-cycle `start` → `done` 3 edges later for one cycle; `bin_out`=8'hFF, `ovf`=0, `invalid`=0; `busy` high for 4 cycles.
- 12'h256 with SATURATE=1 → `bin_out`=8'hFF, `ovf`=1. With SATURATE=0 → `bin_out`=8'h00, `ovf`=1. Also 12'h999 → `ovf`=1, internal acc=999.
- 12'h1A3 → `invalid`=1, `bin_out`=8'hCB (100+100+3=203), `ovf`=0. Also 12'h000 → `bin_out`=8'h00 with all flags 0.
- `start` held high for 20 cycles while `bcd_in` changes every cycle → conversions accepted every 5 edges. Each result matches the `bcd_in` captured on its accepting edge; no `start` is accepted while `busy`=1.
- Assert `rst` asynchronously (between clock edges) during the second CONV cycle of 12'h123 → all outputs are zero immediately and no `done` follows. A subsequent `start` with 12'h042 → `bin_out`=8'h2A.
- DIGITS=1: `bcd_in`=4'h7 → `done` 1 edge after acceptance, `bin_out`=8'h07. `bcd_in`=4'hF → `invalid`=1, `bin_out`=8'h0F.
